// File: rtl/interrupt_controller_pkg.sv
// Shared trap-class encodings, also used by the interrupt vector address generator.
package interrupt_controller_pkg;

  typedef enum logic [2:0] {
    TRAP_NMI    = 3'd0,
    TRAP_ECALL  = 3'd1,
    TRAP_EBREAK = 3'd2,
    TRAP_TMR    = 3'd3,
    TRAP_INT    = 3'd4
  } trap_sel_e;

endpackage

// File: rtl/interrupt_timer.sv
// Machine timer: free-running counter with compare.
// A match clears the counter and produces a one-cycle match pulse.
module interrupt_timer #(
  parameter int TMR_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [TMR_W-1:0] wdata_i,
  output logic [TMR_W-1:0] cnt_o,
  output logic             match_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] cmp_q, cmp_d;

  // A compare load restarts the count and suppresses a match in the same cycle.
  always_comb begin
    cnt_d   = cnt_q;
    cmp_d   = cmp_q;
    match_o = en_i & ~we_i & (cnt_q == cmp_q);
    if (we_i) begin
      cmp_d = wdata_i;
      cnt_d = '0;
    end else if (match_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      cmp_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/interrupt_controller.sv
// Trap collector/prioritiser for the RV32IC core: latches trap events, issues one
// held request until taken, then tracks the in-service handler until mret.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int TMR_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nmi,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               gie,
  input  logic               tmr_en,
  input  logic               tmr_we,
  input  logic [TMR_W-1:0]   tmr_wdata,
  input  logic               take,
  input  logic               mret,
  output logic               interruptF,
  output logic [2:0]         interSel,
  output logic [2:0]         intNum,
  output logic               in_service,
  output logic [TMR_W-1:0]   tmr_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [2:0]         num_q, num_d;
  logic [3:0]         pend_q, pend_d;   // indexed by trap class NMI..TMR
  logic [3:0]         pend_set, pend_clr;
  logic               nmi_prev_q;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] elig;
  logic               tmr_match;
  logic               win_vld;
  logic [2:0]         win_sel;
  logic [2:0]         win_num;

  interrupt_timer #(.TMR_W(TMR_W)) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (tmr_en),
    .we_i    (tmr_we),
    .wdata_i (tmr_wdata),
    .cnt_o   (tmr_cnt),
    .match_o (tmr_match)
  );

  assign elig = irq_q & irq_en & {NUM_IRQ{gie}};

  always_comb begin
    win_vld = 1'b1;
    win_sel = TRAP_NMI;
    win_num = '0;
    if (pend_q[0]) begin
      win_sel = TRAP_NMI;
    end else if (pend_q[1]) begin
      win_sel = TRAP_ECALL;
    end else if (pend_q[2]) begin
      win_sel = TRAP_EBREAK;
    end else if (pend_q[3] && gie) begin
      win_sel = TRAP_TMR;
    end else if (|elig) begin
      win_sel = TRAP_INT;
      // Descending scan so the lowest eligible index is the last written.
      for (int n = NUM_IRQ - 1; n >= 0; n--) begin
        if (elig[n]) win_num = 3'(n);
      end
    end else begin
      win_vld = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    num_d    = num_q;
    pend_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_REQ;
          sel_d   = win_sel;
          num_d   = win_num;
        end
      end
      ST_REQ: begin
        if (take) begin
          state_d = ST_SERVICE;
          if (sel_q != TRAP_INT) pend_clr[sel_q[1:0]] = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (mret) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set terms are OR-ed after the clear so a coincident event is never lost.
  assign pend_set = {tmr_match, ebreak, ecall, nmi & ~nmi_prev_q};
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      num_q      <= '0;
      pend_q     <= '0;
      nmi_prev_q <= 1'b0;
      irq_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      num_q      <= num_d;
      pend_q     <= pend_d;
      nmi_prev_q <= nmi;
      irq_q      <= irq;
    end
  end

  assign interruptF = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERVICE);
  assign interSel   = sel_q;
  assign intNum     = num_q;

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects, latches and prioritises all trap sources of the RV32IC core (NMI, ECALL, EBREAK, timer, 8 external lines) and drives the `interruptF` / `interSel` / `intNum` request consumed by the interrupt vector address generator. Holds one request stable until the core accepts it, then tracks the in-service handler until `mret`. Contains the machine timer (free-running counter plus compare) that sources the TMR trap.

## Interface
- `NUM_IRQ`, 8, number of external interrupt lines (`intNum` is 3 bits; fixed at 8)
- `TMR_W`, 32, timer counter/compare width
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `nmi` in 1: non-maskable interrupt, rising-edge triggered
- `ecall`, `ebreak` in 1: one-cycle pulses from decode
- `irq` in 8: external lines, level-sensitive
- `irq_en` in 8: per-line enable
- `gie` in 1: global enable (mstatus.MIE); masks TMR and INT only
- `tmr_en` in 1: timer count enable
- `tmr_we` in 1: load compare register
- `tmr_wdata` in TMR_W: compare value
- `take` in 1: core redirected PC to vector this cycle
- `mret` in 1: handler return retired this cycle
- `interruptF` out 1: request valid
- `interSel` out 3: source class (encoding below)
- `intNum` out 3: external line index, valid when `interSel`=INT, else 0
- `in_service` out 1: handler active
- `tmr_cnt` out TMR_W: current timer count

## Operation
- Encodings: NMI=0, ECALL=1, EBREAK=2, TMR=3, INT=4.
- Pending flops: `nmi_p` set on rising edge of `nmi` (previous-value flop); `ecall_p` and `ebreak_p` set on pulse; `tmr_p` set on timer match. `irq` is registered once (`irq_q`) and not latched; line n is eligible iff `irq_q[n] & irq_en[n] & gie`.
- Priority (fixed): NMI > ECALL > EBREAK > TMR (needs `gie`) > INT, lowest index first.
- FSM states:
  - IDLE: if any eligible source, capture winner into `interSel`/`intNum` and go to REQ.
  - REQ: `interruptF`=1; selection frozen, even if a higher-priority source arrives or the chosen `irq` line drops. On `take`, clear the winner's pending flop (INT has none) and go to SERVICE.
  - SERVICE: `in_service`=1, `interruptF`=0. On `mret`, go to IDLE. New events keep latching; there is no nesting, and NMI waits too.
- `take` outside REQ and `mret` outside SERVICE are ignored.
- Set and clear of the same pending flop in one cycle: set wins, so no event is lost.
- Timer:
  - If `tmr_en`: `tmr_cnt` increments each cycle.
  - When `tmr_cnt == cmp`: `tmr_p` is set and `tmr_cnt` wraps to 0 in the same edge.
  - `tmr_we`: `cmp <= tmr_wdata` and `tmr_cnt <= 0`; this takes priority over increment and match.
  - Counter wraps naturally at 2^TMR_W−1.

## Timing
- Reset values:
  - State IDLE; all pending flops, `irq_q` and the nmi edge flop 0.
  - `interruptF`=0, `interSel`=0, `intNum`=0, `in_service`=0, `tmr_cnt`=0, `cmp` all ones.
- Latency: input sampled at edge k (pending set or `irq_q` captured) → REQ after edge k+1, so `interruptF` is visible 2 cycles after the input is asserted.
- `take` at edge j → `interruptF`=0 and `in_service`=1 after j. `mret` at edge m → IDLE after m. Earliest next `interruptF` is after m+1.
- `interSel`/`intNum` are registered; they are stable for the whole REQ interval and hold their last value otherwise.
- Reset mid-operation: pending events are discarded and an active REQ/SERVICE is abandoned.

## Structure
- The trap-class encodings NMI/ECALL/EBREAK/TMR/INT live in the shared defines header already used by the vector address generator; do not duplicate them locally.
- FSM state encodings are local parameters.
- One sub-module: `interrupt_timer` (counter, compare register, match pulse output).

## Test plan
- `irq[5]`=1, `irq_en`=8'h20, `gie`=1 → `interruptF`=1, `interSel`=4, `intNum`=5 two cycles later; `take` → `in_service`=1; `mret` → IDLE.
- `irq`=8'h0C and `nmi` rises in the same cycle → NMI (sel 0) first. After take and mret → INT with `intNum`=2.
- `tmr_we` with `tmr_wdata`=10, `tmr_en`=1, `gie`=0 → `tmr_p` set but no request. Raise `gie` → `interSel`=3. `tmr_cnt` is back at 0 after the match.
- In REQ with ECALL selected, pulse `nmi` → outputs stay ECALL until `take`. NMI is requested only after `mret`.
- `ebreak` pulse coinciding with `take` of an EBREAK → second EBREAK request follows the `mret`.
- Assert `rst` during SERVICE with `ecall_p` pending → all outputs 0 next cycle and no request afterward.
